// File: rtl/isram_boot_loader.sv
// isram_boot_loader: streams a 32-bit boot image into the byte-lane ISRAM.
// Optional zero-fill of the untouched tail: define ISRAM_LOADER_ZERO_FILL_EN.
module isram_boot_loader #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata0,
    output logic [7:0]    sram_wdata1,
    output logic [7:0]    sram_wdata2,
    output logic [7:0]    sram_wdata3,
    output logic [AW:0]   load_cnt,
    output logic          load_done,
    output logic          overflow,
    output logic          cpu_rst_hold
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
`ifdef ISRAM_LOADER_ZERO_FILL_EN
        FILL = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t state;

`ifdef ISRAM_LOADER_ZERO_FILL_EN
    logic [AW-1:0] fill_ptr;
    logic          fill_end;
    assign fill_end = (fill_ptr == LAST_IDX[AW-1:0]);
`endif

    logic hs;
    logic at_end;

    // accept only while the registered state is LOAD, so a beat after s_last is refused
    assign hs     = s_valid & s_ready & (state == LOAD);
    assign at_end = (load_cnt == LAST_IDX);

    // loader FSM with all outputs registered; SRAM strobes are one-cycle pulses
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            sram_cen     <= 1'b1;
            sram_wen     <= 1'b1;
            sram_addr    <= '0;
            sram_wdata0  <= '0;
            sram_wdata1  <= '0;
            sram_wdata2  <= '0;
            sram_wdata3  <= '0;
            load_cnt     <= '0;
            load_done    <= 1'b0;
            overflow     <= 1'b0;
            cpu_rst_hold <= 1'b1;
`ifdef ISRAM_LOADER_ZERO_FILL_EN
            fill_ptr     <= '0;
`endif
        end else begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;

            if (hs) begin
                sram_cen    <= 1'b0;
                sram_wen    <= 1'b0;
                sram_addr   <= load_cnt[AW-1:0];
                sram_wdata0 <= s_data[31:24];
                sram_wdata1 <= s_data[23:16];
                sram_wdata2 <= s_data[15:8];
                sram_wdata3 <= s_data[7:0];
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        load_cnt     <= '0;
                        load_done    <= 1'b0;
                        overflow     <= 1'b0;
                        cpu_rst_hold <= 1'b1;
                        s_ready      <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (s_last) begin
                            s_ready <= 1'b0;
`ifdef ISRAM_LOADER_ZERO_FILL_EN
                            if (at_end) begin
                                state <= DONE;
                            end else begin
                                fill_ptr <= load_cnt[AW-1:0] + 1'b1;
                                state    <= FILL;
                            end
`else
                            state <= DONE;
`endif
                        end else if (at_end) begin
                            overflow <= 1'b1;
                            s_ready  <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
`ifdef ISRAM_LOADER_ZERO_FILL_EN
                FILL: begin
                    sram_cen    <= 1'b0;
                    sram_wen    <= 1'b0;
                    sram_addr   <= fill_ptr;
                    sram_wdata0 <= '0;
                    sram_wdata1 <= '0;
                    sram_wdata2 <= '0;
                    sram_wdata3 <= '0;
                    if (fill_end) begin
                        state <= DONE;
                    end else begin
                        fill_ptr <= fill_ptr + 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (start) begin
                        load_cnt     <= '0;
                        load_done    <= 1'b0;
                        overflow     <= 1'b0;
                        cpu_rst_hold <= 1'b1;
                        s_ready      <= 1'b1;
                        state        <= LOAD;
                    end else begin
                        load_done    <= 1'b1;
                        cpu_rst_hold <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isram_boot_loader.sv
// tb_isram_boot_loader: directed bench with an SRAM model fed by the write strobes.
// Expectations follow ISRAM_LOADER_ZERO_FILL_EN when it is defined.
module tb_isram_boot_loader;

    localparam int DEPTH = 16384;
    localparam int AW    = 14;

`ifdef ISRAM_LOADER_ZERO_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic          hclk = 1'b0;
    logic          hrst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_last;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata0;
    logic [7:0]    sram_wdata1;
    logic [7:0]    sram_wdata2;
    logic [7:0]    sram_wdata3;
    logic [AW:0]   load_cnt;
    logic          load_done;
    logic          overflow;
    logic          cpu_rst_hold;

    isram_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .hclk        (hclk),
        .hrst        (hrst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata0 (sram_wdata0),
        .sram_wdata1 (sram_wdata1),
        .sram_wdata2 (sram_wdata2),
        .sram_wdata3 (sram_wdata3),
        .load_cnt    (load_cnt),
        .load_done   (load_done),
        .overflow    (overflow),
        .cpu_rst_hold(cpu_rst_hold)
    );

    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [DEPTH];
    int  wcnt     = 0;
    int  seq_err  = 0;
    int  gap_err  = 0;
    int  cyc      = 0;
    int  first_wr = 0;
    int  last_wr  = 0;
    int  done_cyc = 0;
    bit  gap      = 1'b0;
    bit  hs_q     = 1'b0;
    bit  done_q   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM model plus write-ordering and gap monitors
    always @(posedge hclk) begin : mon
        bit wr;
        wr = !sram_cen && !sram_wen;
        if (gap && (wr != hs_q)) gap_err++;
        if (wr) begin
            if (sram_addr != wcnt[AW-1:0]) seq_err++;
            if (wcnt == 0) first_wr = cyc;
            mem[sram_addr] = {sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3};
            wcnt++;
            last_wr = cyc;
        end
        if (load_done && !done_q) done_cyc = cyc;
        done_q = load_done;
        hs_q = s_valid && s_ready;
        cyc++;
    end

    task automatic do_start();
        wcnt = 0;
        seq_err = 0;
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t;
        t = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!s_ready && t < 100) begin
            @(negedge hclk);
            t++;
        end
        if (t >= 100) check("send_timeout", 0, 1);
        @(negedge hclk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int t;
        t = 0;
        while (!load_done && t < lim) begin
            @(negedge hclk);
            t++;
        end
        check("done_timeout", load_done, 1);
        @(negedge hclk);
    endtask

    task automatic check_reset(input string p);
        check({p, "_s_ready"}, s_ready, 0);
        check({p, "_cen"}, sram_cen, 1);
        check({p, "_wen"}, sram_wen, 1);
        check({p, "_addr"}, sram_addr, 0);
        check({p, "_wdata"}, {sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3}, 0);
        check({p, "_load_cnt"}, load_cnt, 0);
        check({p, "_load_done"}, load_done, 0);
        check({p, "_overflow"}, overflow, 0);
        check({p, "_cpu_rst_hold"}, cpu_rst_hold, 1);
    endtask

    initial begin
        int errs;
        int acc;
        hrst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
        repeat (3) @(negedge hclk);
        check_reset("rst");
        hrst = 1'b0;
        @(negedge hclk);
        check_reset("idle");

        // 4-word image, start pulses inside LOAD (and FILL) must be ignored
        do_start();
        check("ready_rise", s_ready, 1);
        send(32'h1122_3344, 1'b0);
        start = 1'b1;
        send(32'h5566_7788, 1'b0);
        start = 1'b0;
        send(32'h99AA_BBCC, 1'b0);
        send(32'hDDEE_FF00, 1'b1);
        if (FILL_ON) begin
            repeat (50) @(negedge hclk);
            start = 1'b1;
            @(negedge hclk);
            start = 1'b0;
        end
        wait_done(20000);
        check("a_addr0", mem[0], 32'h1122_3344);
        check("a_addr1", mem[1], 32'h5566_7788);
        check("a_addr3", mem[3], 32'hDDEE_FF00);
        check("a_addr4", mem[4], FILL_ON ? 32'h0 : 32'hDEAD_BEEF);
        errs = 0;
        for (int i = 4; i < DEPTH; i++)
            if (mem[i] != (FILL_ON ? 32'h0 : 32'hDEAD_BEEF)) errs++;
        check("a_tail", errs, 0);
        check("a_wcnt", wcnt, FILL_ON ? DEPTH : 4);
        check("a_wr_span", last_wr - first_wr, FILL_ON ? DEPTH - 1 : 3);
        check("a_seq", seq_err, 0);
        check("a_done_lat", done_cyc - last_wr, 1);
        check("a_load_cnt", load_cnt, 4);
        check("a_hold", cpu_rst_hold, 0);
        check("a_ready", s_ready, 0);
        check("a_ovf", overflow, 0);

        // overflow: DEPTH words without s_last, then one extra beat refused
        do_start();
        check("o_hold", cpu_rst_hold, 1);
        check("o_done_clr", load_done, 0);
        for (int i = 0; i < DEPTH; i++) send(32'(i + 1), 1'b0);
        s_data = 32'hBAD0_BAD0;
        s_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_ready) acc++;
            @(negedge hclk);
        end
        s_valid = 1'b0;
        wait_done(100);
        check("o_accept_extra", acc, 0);
        check("o_wcnt", wcnt, DEPTH);
        check("o_seq", seq_err, 0);
        check("o_addr0", mem[0], 32'h1);
        check("o_addr_last", mem[DEPTH-1], 32'(DEPTH));
        check("o_overflow", overflow, 1);
        check("o_done", load_done, 1);
        check("o_ready", s_ready, 0);
        check("o_load_cnt", load_cnt, DEPTH);

        // 64 words with random valid gaps
        do_start();
        gap = 1'b1;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++)
                @(negedge hclk);
            send(32'hC0DE_0000 + 32'(i), i == 63);
        end
        @(posedge hclk);
        #1 gap = 1'b0;
        wait_done(20000);
        errs = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] != 32'hC0DE_0000 + 32'(i)) errs++;
        check("r_data", errs, 0);
        check("r_gap", gap_err, 0);
        check("r_seq", seq_err, 0);
        check("r_wcnt", wcnt, FILL_ON ? DEPTH : 64);
        check("r_load_cnt", load_cnt, 64);

        // reset mid-LOAD after 10 words, then reload from address 0
        do_start();
        for (int i = 0; i < 10; i++) send(32'h7000_0000 + 32'(i), 1'b0);
        check("m_load_cnt10", load_cnt, 10);
        hrst = 1'b1;
        @(negedge hclk);
        hrst = 1'b0;
        check_reset("mid");
        do_start();
        check("m_restart_cnt", load_cnt, 0);
        send(32'h8000_0001, 1'b0);
        send(32'h8000_0002, 1'b1);
        wait_done(20000);
        check("m_addr0", mem[0], 32'h8000_0001);
        check("m_addr1", mem[1], 32'h8000_0002);
        check("m_addr2", mem[2], FILL_ON ? 32'h0 : 32'h7000_0002);
        check("m_seq", seq_err, 0);
        check("m_load_cnt", load_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
